mci_mcu_trace_drain: RTL and testbench

MCI_MCU_TRACE_DRAIN -- requirements
Module: mci_mcu_trace_drain

---
 rtl/mci_mcu_trace_drain.sv | 192 +++++++++++++++++++
 tb/tb_mci_mcu_trace_drain.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mci_mcu_trace_drain.sv
// rtl/mci_mcu_trace_drain.sv - drains the MCU trace buffer over DMI into 128-bit packets
// One DMI read-pointer write per dword; four dwords are assembled per packet.
module mci_mcu_trace_drain #(
  parameter int         NUM_TRACE_ENTRIES         = 64,
  parameter logic [6:0] DMI_REG_TRACE_RD_PTR_ADDR = 7'h5D,
  parameter int         RD_LAT                    = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         debug_en,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  trace_status_i,
  input  logic [31:0]  trace_wr_ptr_i,
  input  logic [31:0]  trace_data_i,
  output logic         dmi_reg_wen,
  output logic [6:0]   dmi_reg_addr,
  output logic [31:0]  dmi_reg_wdata,
  output logic         pkt_valid,
  input  logic         pkt_ready,
  output logic [127:0] pkt_data,
  output logic         pkt_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int ENT_W = $clog2(NUM_TRACE_ENTRIES);
  localparam int PTR_W = ENT_W + 2;
  localparam int CNT_W = ENT_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_TRACE_ENTRIES);
  localparam logic [CNT_W-1:0] ONE_LEFT   = CNT_W'(1);
  localparam logic [2:0]       LAT        = 3'(RD_LAT);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WR_PTR,
    WAIT,
    CAPTURE,
    SEND,
    FINISH
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_remaining;
  logic [2:0]         r_wait_cnt;
  logic [127:0]       r_pkt_data;
  logic               r_pkt_valid;
  logic               r_pkt_last;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic               r_dmi_wen;
  logic [6:0]         r_dmi_addr;
  logic [31:0]        r_dmi_wdata;

  logic [PTR_W-1:0]   w_snap_ptr;
  logic               w_wrapped;
  logic               w_valid_data;
  logic [PTR_W-1:0]   w_start_ptr;
  logic [CNT_W-1:0]   w_count;
  logic [PTR_W-1:0]   w_ptr_inc;
  logic [1:0]         w_slot;
  logic               w_kill;
  logic               w_unused;

  assign w_snap_ptr   = trace_wr_ptr_i[PTR_W-1:0];
  assign w_wrapped    = trace_status_i[1];
  assign w_valid_data = trace_status_i[0];
  assign w_start_ptr  = w_wrapped ? w_snap_ptr : '0;
  assign w_count      = w_wrapped ? FULL_COUNT : {1'b0, w_snap_ptr[PTR_W-1:2]};
  assign w_ptr_inc    = r_ptr + PTR_W'(1);
  assign w_slot       = r_ptr[1:0];
  assign w_unused     = ^{trace_status_i[31:2], trace_wr_ptr_i[31:PTR_W]};

  // Abort and loss of debug_en take priority over every busy state, including FINISH.
  assign w_kill = (r_state != IDLE) && (abort || !debug_en);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
      r_wait_cnt  <= '0;
      r_pkt_data  <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_dmi_wen   <= 1'b0;
      r_dmi_addr  <= '0;
      r_dmi_wdata <= '0;
    end else begin
      r_dmi_wen   <= 1'b0;
      r_dmi_addr  <= '0;
      r_dmi_wdata <= '0;
      r_done      <= 1'b0;
      if (w_kill) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_err       <= 1'b1;
        r_pkt_valid <= 1'b0;
        r_pkt_last  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && debug_en) begin
              r_state <= SETUP;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
            end
          end
          SETUP: begin
            r_ptr       <= w_start_ptr;
            r_remaining <= w_count;
            if (!w_valid_data || (w_count == '0)) begin
              r_state <= FINISH;
            end else begin
              r_state     <= WR_PTR;
              r_dmi_wen   <= 1'b1;
              r_dmi_addr  <= DMI_REG_TRACE_RD_PTR_ADDR;
              r_dmi_wdata <= 32'(w_start_ptr);
            end
          end
          WR_PTR: begin
            r_state    <= WAIT;
            r_wait_cnt <= 3'd1;
          end
          WAIT: begin
            if (r_wait_cnt == LAT) begin
              r_state <= CAPTURE;
            end else begin
              r_wait_cnt <= r_wait_cnt + 3'd1;
            end
          end
          CAPTURE: begin
            r_pkt_data[{w_slot, 5'b0} +: 32] <= trace_data_i;
            r_ptr <= w_ptr_inc;
            if (w_slot == 2'd3) begin
              r_state     <= SEND;
              r_pkt_valid <= 1'b1;
              r_pkt_last  <= (r_remaining == ONE_LEFT);
            end else begin
              r_state     <= WR_PTR;
              r_dmi_wen   <= 1'b1;
              r_dmi_addr  <= DMI_REG_TRACE_RD_PTR_ADDR;
              r_dmi_wdata <= 32'(w_ptr_inc);
            end
          end
          SEND: begin
            if (pkt_ready) begin
              r_pkt_valid <= 1'b0;
              r_pkt_last  <= 1'b0;
              r_remaining <= r_remaining - ONE_LEFT;
              if (r_remaining == ONE_LEFT) begin
                r_state <= FINISH;
              end else begin
                r_state     <= WR_PTR;
                r_dmi_wen   <= 1'b1;
                r_dmi_addr  <= DMI_REG_TRACE_RD_PTR_ADDR;
                r_dmi_wdata <= 32'(r_ptr);
              end
            end
          end
          FINISH: begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dmi_reg_wen   = r_dmi_wen;
  assign dmi_reg_addr  = r_dmi_addr;
  assign dmi_reg_wdata = r_dmi_wdata;
  assign pkt_valid     = r_pkt_valid;
  assign pkt_data      = r_pkt_data;
  assign pkt_last      = r_pkt_last;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule

// File: tb/tb_mci_mcu_trace_drain.sv
// tb/tb_mci_mcu_trace_drain.sv - self-checking bench for mci_mcu_trace_drain
// Trace buffer and drain expectations come from a dword-array model of the buffer.
module tb_mci_mcu_trace_drain;
  localparam int N = 64;
  localparam int NDW = N * 4;
  localparam int RD_LAT = 2;
  localparam logic [6:0] ADDR = 7'h5D;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic debug_en = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pkt_ready = 1'b0;
  logic [31:0] trace_status_i = '0;
  logic [31:0] trace_wr_ptr_i = '0;
  logic [31:0] trace_data_i;
  logic dmi_reg_wen;
  logic [6:0] dmi_reg_addr;
  logic [31:0] dmi_reg_wdata;
  logic pkt_valid;
  logic [127:0] pkt_data;
  logic pkt_last;
  logic busy;
  logic done;
  logic err;

  mci_mcu_trace_drain #(
    .NUM_TRACE_ENTRIES(N),
    .DMI_REG_TRACE_RD_PTR_ADDR(ADDR),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_b(rst_b), .debug_en(debug_en), .start(start), .abort(abort),
    .trace_status_i(trace_status_i), .trace_wr_ptr_i(trace_wr_ptr_i), .trace_data_i(trace_data_i),
    .dmi_reg_wen(dmi_reg_wen), .dmi_reg_addr(dmi_reg_addr), .dmi_reg_wdata(dmi_reg_wdata),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_last(pkt_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NDW];
  int cyc = 0;
  int rd_ptr = 0;
  int age = 15;
  always @(posedge clk) cyc <= cyc + 1;

  // Trace data becomes valid RD_LAT cycles after the read-pointer write.
  assign trace_data_i = (age >= RD_LAT) ? mem[rd_ptr] : 32'hDEAD_BEEF;

  int q_dmi[$];
  int q_dmi_cyc[$];
  logic [127:0] q_pkt[$];
  bit q_last[$];
  int q_hs_cyc[$];
  int done_cnt = 0;
  int done_cyc = 0;
  int mon_err = 0;
  int valid_cycles = 0;
  bit clr = 1'b0;
  bit p_stall = 1'b0;
  logic [127:0] p_data = '0;
  logic p_last = 1'b0;

  always @(negedge clk) begin
    if (clr) begin
      q_dmi.delete(); q_dmi_cyc.delete(); q_pkt.delete(); q_last.delete(); q_hs_cyc.delete();
      done_cnt <= 0; mon_err <= 0; valid_cycles <= 0; p_stall <= 1'b0;
    end else begin
      if (dmi_reg_wen) begin
        q_dmi.push_back(int'(dmi_reg_wdata));
        q_dmi_cyc.push_back(cyc);
      end
      mon_err <= mon_err
               + int'(dmi_reg_wen && dmi_reg_addr != ADDR)
               + int'(!dmi_reg_wen && (dmi_reg_addr != 7'd0 || dmi_reg_wdata != 32'd0))
               + int'(pkt_last && !pkt_valid)
               + int'(p_stall && (!pkt_valid || pkt_data != p_data || pkt_last != p_last || dmi_reg_wen));
      if (pkt_valid) valid_cycles <= valid_cycles + 1;
      if (pkt_valid && pkt_ready) begin
        q_pkt.push_back(pkt_data);
        q_last.push_back(pkt_last);
        q_hs_cyc.push_back(cyc);
      end
      p_stall <= pkt_valid && !pkt_ready;
      p_data  <= pkt_data;
      p_last  <= pkt_last;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
    if (dmi_reg_wen) begin
      rd_ptr <= int'(dmi_reg_wdata % NDW);
      age <= 0;
    end else if (age < 15) begin
      age <= age + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic pulse_start(output int s_cyc);
    start = 1'b1;
    s_cyc = cyc;
    tick(1);
    start = 1'b0;
  endtask

  function automatic int exp_count(bit w, bit v, int wp);
    if (!v) return 0;
    return w ? N : (wp & (NDW - 1)) / 4;
  endfunction

  function automatic int exp_start(bit w, int wp);
    return w ? (wp & (NDW - 1)) : 0;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < NDW; i++) mem[i] = $urandom;
  endtask

  task automatic wait_idle(output bit timed_out, input bit rnd_ready, input bit perturb);
    timed_out = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      if (perturb && i >= 1) begin
        trace_wr_ptr_i = $urandom;
        trace_status_i = $urandom;
      end
      if (rnd_ready) pkt_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    tick(2);
  endtask

  task automatic run_drain(bit w, bit v, int wp, bit rnd_ready, bit perturb,
                           output bit timed_out, output int s_cyc);
    trace_status_i = {30'd0, w, v};
    trace_wr_ptr_i = wp;
    pkt_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    clear_mon();
    pulse_start(s_cyc);
    wait_idle(timed_out, rnd_ready, perturb);
  endtask

  task automatic check_drain(string tag, bit w, bit v, int wp, bit timed_out, int s_cyc, bit timing);
    int cnt;
    int st;
    int bad;
    logic [127:0] e;
    cnt = exp_count(w, v, wp);
    st = exp_start(w, wp);
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_ndmi"}, q_dmi.size(), cnt * 4);
    bad = 0;
    for (int i = 0; i < q_dmi.size() && i < cnt * 4; i++)
      if (q_dmi[i] != (st + i) % NDW) bad++;
    check({tag, "_dmi_seq"}, bad, 0);
    check({tag, "_npkt"}, q_pkt.size(), cnt);
    bad = 0;
    for (int k = 0; k < q_pkt.size() && k < cnt; k++) begin
      for (int j = 0; j < 4; j++) e[32*j +: 32] = mem[(st + 4*k + j) % NDW];
      if (q_pkt[k] !== e) bad++;
      if (q_last[k] != (k == cnt - 1)) bad++;
    end
    check({tag, "_pkt_data_last"}, bad, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_monitor"}, mon_err, 0);
    if (timing) begin
      if (cnt == 0) begin
        check({tag, "_done_lat"}, done_cyc - s_cyc, 3);
      end else begin
        bad = 0;
        if (q_dmi_cyc.size() > 0 && q_dmi_cyc[0] != s_cyc + 2) bad++;
        for (int i = 1; i < q_dmi_cyc.size(); i++)
          if (q_dmi_cyc[i] - q_dmi_cyc[i-1] != ((i % 4 == 0) ? RD_LAT + 3 : RD_LAT + 2)) bad++;
        for (int k = 1; k < q_hs_cyc.size(); k++)
          if (q_hs_cyc[k] - q_hs_cyc[k-1] != 4 * (RD_LAT + 2) + 1) bad++;
        if (q_hs_cyc.size() > 0 && done_cyc != q_hs_cyc[q_hs_cyc.size()-1] + 2) bad++;
        check({tag, "_timing"}, bad, 0);
      end
    end
  endtask

  typedef struct {
    bit wrapped;
    bit valid;
    int wr_ptr;
    int exp_npkt;
    int exp_first;
    int exp_lastw;
  } vec_t;

  vec_t vt[9];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit to;
    int s;
    int nv;
    vt[0] = '{1'b0, 1'b0, 12, 0, -1, -1};
    vt[1] = '{1'b0, 1'b1, 12, 3, 0, 11};
    vt[2] = '{1'b1, 1'b1, 8, 64, 8, 7};
    vt[3] = '{1'b0, 1'b1, 0, 0, -1, -1};
    vt[4] = '{1'b0, 1'b1, 4, 1, 0, 3};
    vt[5] = '{1'b0, 1'b1, 252, 63, 0, 251};
    vt[6] = '{1'b1, 1'b1, 0, 64, 0, 255};
    vt[7] = '{1'b1, 1'b1, 252, 64, 252, 251};
    vt[8] = '{1'b0, 1'b1, 268, 3, 0, 11};

    fill_mem();
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_pkt_last", pkt_last, 0);
    check("rst_dmi", {dmi_reg_wen, dmi_reg_addr, dmi_reg_wdata}, 0);
    check("rst_pkt_data", pkt_data, 0);
    debug_en = 1'b1;
    rst_b = 1'b1;
    tick(2);

    for (int i = 0; i < 9; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      fill_mem();
      run_drain(vt[i].wrapped, vt[i].valid, vt[i].wr_ptr, 1'b0, 1'b0, to, s);
      check_drain(tag, vt[i].wrapped, vt[i].valid, vt[i].wr_ptr, to, s, 1'b1);
      check({tag, "_tbl_npkt"}, q_pkt.size(), vt[i].exp_npkt);
      check({tag, "_tbl_first"}, q_dmi.size() > 0 ? q_dmi[0] : -1, vt[i].exp_first);
      check({tag, "_tbl_lastw"}, q_dmi.size() > 0 ? q_dmi[q_dmi.size()-1] : -1, vt[i].exp_lastw);
    end

    // Consumer stalls for 10 cycles on the first packet.
    fill_mem();
    trace_status_i = 32'd1;
    trace_wr_ptr_i = 32'd8;
    pkt_ready = 1'b0;
    clear_mon();
    pulse_start(s);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (pkt_valid) begin to = 1'b0; break; end
      tick(1);
    end
    check("stall_valid_timeout", to, 0);
    tick(10);
    check("stall_valid_held", pkt_valid, 1);
    check("stall_no_dmi", q_dmi.size(), 4);
    check("stall_no_accept", q_pkt.size(), 0);
    pkt_ready = 1'b1;
    wait_idle(to, 1'b0, 1'b0);
    check_drain("stall", 1'b0, 1'b1, 8, to, s, 1'b0);

    // Abort during WAIT of packet 2.
    trace_status_i = 32'd1;
    trace_wr_ptr_i = 32'd16;
    pkt_ready = 1'b1;
    clear_mon();
    pulse_start(s);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (q_dmi.size() >= 5) begin to = 1'b0; break; end
      tick(1);
    end
    check("abort_reach_timeout", to, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_err", err, 1);
    check("abort_pkt_valid", pkt_valid, 0);
    nv = valid_cycles;
    tick(60);
    check("abort_no_valid", valid_cycles, nv);
    check("abort_no_dmi", q_dmi.size(), 5);
    check("abort_npkt", q_pkt.size(), 1);
    check("abort_no_done", done_cnt, 0);
    check("abort_err_sticky", err, 1);

    // Abort coincident with a packet handshake.
    clear_mon();
    pulse_start(s);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (pkt_valid) begin to = 1'b0; break; end
      tick(1);
    end
    check("abort_hs_timeout", to, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_hs_busy", busy, 0);
    check("abort_hs_err", err, 1);
    tick(20);
    check("abort_hs_npkt", q_pkt.size(), 1);
    check("abort_hs_no_dmi", q_dmi.size(), 4);
    check("abort_hs_no_done", done_cnt, 0);

    // debug_en gating and loss mid-drain.
    debug_en = 1'b0;
    trace_wr_ptr_i = 32'd8;
    clear_mon();
    pulse_start(s);
    tick(3);
    check("dbg_start_ignored", busy, 0);
    check("dbg_no_dmi", q_dmi.size(), 0);
    debug_en = 1'b1;
    clear_mon();
    pulse_start(s);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (q_dmi.size() >= 3) begin to = 1'b0; break; end
      tick(1);
    end
    check("dbg_reach_timeout", to, 0);
    debug_en = 1'b0;
    tick(1);
    check("dbg_loss_busy", busy, 0);
    check("dbg_loss_err", err, 1);
    tick(20);
    check("dbg_loss_no_done", done_cnt, 0);
    debug_en = 1'b1;
    run_drain(1'b0, 1'b1, 8, 1'b0, 1'b0, to, s);
    check_drain("dbg_restart", 1'b0, 1'b1, 8, to, s, 1'b1);

    // Reset in the middle of a wrapped drain.
    trace_status_i = 32'd3;
    trace_wr_ptr_i = 32'd40;
    clear_mon();
    pulse_start(s);
    tick(40);
    rst_b = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_outs", {pkt_valid, pkt_last, dmi_reg_wen, err, done}, 0);
    tick(2);
    rst_b = 1'b1;
    nv = q_dmi.size();
    tick(50);
    check("mid_rst_no_done", done_cnt, 0);
    check("mid_rst_no_dmi", q_dmi.size(), nv);
    check("mid_rst_idle", busy, 0);

    // Randomized drains with random back-pressure and changing trace inputs.
    for (int r = 0; r < 6; r++) begin
      bit w;
      bit v;
      int wp;
      fill_mem();
      w = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 7) != 0);
      wp = w ? 4 * int'($urandom_range(0, N - 1)) : int'($urandom_range(0, 90));
      run_drain(w, v, wp, 1'b1, 1'b1, to, s);
      check_drain($sformatf("rnd%0d", r), w, v, wp, to, s, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
